seven_seg_display: RTL

Multiplexed hexadecimal seven-segment display controller downstream of the core's memory-mapped 4-bit display output. Each strobed nibble shifts into a DIGITS-deep digit register. A prescaled scan counter time-multiplexes the digits onto shared active-low segment and anode lines, with a dead-time cycle between digits to suppress ghosting. Optional leading-zero blanking and an overflow indicator on the decimal point are provided.

---
 rtl/seven_seg_display.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_display.sv
// Multiplexed hex seven-segment display controller: shifts strobed nibbles into a
// digit store and time-multiplexes them onto active-low anode/segment lines.
module seven_seg_display #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        nibble_i,
  input  logic              nibble_valid_i,
  input  logic              clear_i,
  input  logic              blank_leading_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o,
  output logic              dp_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [PW-1:0] P_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

  typedef enum logic [1:0] {
    SLOT_DEAD,
    SLOT_DRIVE,
    SLOT_BLANK
  } slot_t;

  logic [3:0]        digit [DIGITS];
  logic [CW-1:0]     cnt;
  logic              ovf;

  logic [PW-1:0]     p, p_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  slot_t             slot;

  logic [DIGITS-1:0] an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit store, fill count and overflow; clear beats a coincident strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        digit[k] <= '0;
      end
      cnt <= '0;
      ovf <= 1'b0;
    end else if (nibble_valid_i) begin
      for (int unsigned k = 1; k < DIGITS; k++) begin
        digit[k] <= digit[k-1];
      end
      digit[0] <= nibble_i;
      if (cnt == CNT_FULL) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Scan position: prescaler and digit index, unaffected by clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p   <= '0;
      idx <= '0;
    end else begin
      p   <= p_nxt;
      idx <= idx_nxt;
    end
  end

  always_comb begin
    p_nxt   = p + 1'b1;
    idx_nxt = idx;
    if (p == P_LAST) begin
      p_nxt   = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    slot = SLOT_DRIVE;
    if (p == '0) begin
      slot = SLOT_DEAD;
    end else if (blank_leading_i && (idx != '0) && (CW'(idx) >= cnt)) begin
      slot = SLOT_BLANK;
    end
  end

  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (slot == SLOT_DRIVE) begin
      an_nxt  = ~(DIGITS'(1) << idx);
      seg_nxt = decode(digit[idx]);
      dp_nxt  = ~((idx == IDX_LAST) && ovf);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o  <= '1;
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
      dp_o  <= dp_nxt;
    end
  end

endmodule
